// File: rtl/not_gate_pkg.sv
// rtl/not_gate_pkg.sv - shared defaults and saturating-increment helper for the NOT gate unit
package not_gate_pkg;

  localparam int unsigned NOT_GATE_WIDTH_DEF = 1;
  localparam int unsigned NOT_GATE_CNT_W_DEF = 16;

  // Increment value, saturating at the all-ones value of a counter that is width bits wide (width <= 32)
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/not_gate_toggle_cnt.sv
// rtl/not_gate_toggle_cnt.sv - saturating count of cycles in which the input bus changed
module not_gate_toggle_cnt
  import not_gate_pkg::*;
#(
  parameter int unsigned WIDTH = NOT_GATE_WIDTH_DEF,
  parameter int unsigned CNT_W = NOT_GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] a_prev_d, a_prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Any number of differing bits in one cycle counts as a single toggle
  always_comb begin
    a_prev_d = a;
    cnt_d    = cnt_q;
    if (a != a_prev_q) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      a_prev_q <= a_prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;

endmodule

// File: rtl/not_gate_unit.sv
// rtl/not_gate_unit.sv - bitwise inverter with enable-gated registered copy and toggle counter
// Optional self-check of the registered path is built when NOT_GATE_SELFCHECK_EN is defined.
module not_gate_unit
  import not_gate_pkg::*;
#(
  parameter int unsigned WIDTH = NOT_GATE_WIDTH_DEF,
  parameter int unsigned CNT_W = NOT_GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_valid,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             check_err
);

  logic [WIDTH-1:0] y_q_d, y_q_q;
  logic             y_valid_d, y_valid_q;

  // Combinational path stays live through reset
  assign y = ~a;

  always_comb begin
    y_q_d     = y_q_q;
    y_valid_d = en;
    if (en) begin
      y_q_d = ~a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_q     <= '1;
      y_valid_q <= 1'b0;
    end else begin
      y_q_q     <= y_q_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_q     = y_q_q;
  assign y_valid = y_valid_q;

  not_gate_toggle_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_toggle_cnt (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .toggle_cnt (toggle_cnt)
  );

`ifdef NOT_GATE_SELFCHECK_EN
  logic [WIDTH-1:0] a_q_d, a_q_q;
  logic             check_err_d, check_err_q;

  // a_q mirrors the operand that produced y_q, so y_q must always equal ~a_q once valid
  always_comb begin
    a_q_d       = en ? a : a_q_q;
    check_err_d = check_err_q;
    if (y_valid_q && (y_q_q != ~a_q_q)) begin
      check_err_d = 1'b1;
    end
    if (y != ~a) begin
      check_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q_q       <= '0;
      check_err_q <= 1'b0;
    end else begin
      a_q_q       <= a_q_d;
      check_err_q <= check_err_d;
    end
  end

  assign check_err = check_err_q;
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_not_gate_unit.sv
// tb/tb_not_gate_unit.sv - directed self-checking bench for not_gate_unit (NOT_GATE_SELFCHECK_EN optional)
module tb_not_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u1: WIDTH=1 plain gate; u8: WIDTH=8 main datapath; u3: CNT_W=3 saturation
  logic        rst1, a1, en1, y1, yq1, yv1, ce1;
  logic [15:0] cnt1;
  logic        rst8, en8, yv8, ce8;
  logic [7:0]  a8, y8, yq8;
  logic [15:0] cnt8;
  logic        rst3, a3, en3, y3, yq3, yv3, ce3;
  logic [2:0]  cnt3;

  int n_vec = 0;
  int n_err = 0;

  not_gate_unit #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .en(en1), .y(y1), .y_q(yq1),
    .y_valid(yv1), .toggle_cnt(cnt1), .check_err(ce1)
  );

  not_gate_unit #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst8), .a(a8), .en(en8), .y(y8), .y_q(yq8),
    .y_valid(yv8), .toggle_cnt(cnt8), .check_err(ce8)
  );

  not_gate_unit #(.WIDTH(1), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst3), .a(a3), .en(en3), .y(y3), .y_q(yq3),
    .y_valid(yv3), .toggle_cnt(cnt3), .check_err(ce3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tv [5];
    tv = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};

    rst1 = 1'b1; a1 = 1'b0; en1 = 1'b1;
    rst8 = 1'b1; a8 = 8'h00; en8 = 1'b0;
    rst3 = 1'b1; a3 = 1'b0; en3 = 1'b0;

    // WIDTH=1 under reset: y follows ~a, registered state stays at reset values
    tick();
    chk("w1_y_a0", 32'(y1), 32'h1);
    chk("w1_yq_rst", 32'(yq1), 32'h1);
    chk("w1_yv_rst", 32'(yv1), 32'h0);
    chk("w1_cnt_rst", 32'(cnt1), 32'h0);
    chk("w8_yq_rst", 32'(yq8), 32'hFF);
    chk("w8_err_rst", 32'(ce8), 32'h0);
    #10;
    a1 = 1'b1;
    #1;
    chk("w1_y_a1", 32'(y1), 32'h0);
    tick();
    chk("w1_yq_hold", 32'(yq1), 32'h1);
    chk("w1_yv_hold", 32'(yv1), 32'h0);
    chk("w1_cnt_hold", 32'(cnt1), 32'h0);

    // WIDTH=8 load and hold
    rst8 = 1'b0; en8 = 1'b1; a8 = 8'hA5;
    #1;
    chk("w8_y_comb", 32'(y8), 32'h5A);
    tick();
    chk("w8_yq_load", 32'(yq8), 32'h5A);
    chk("w8_yv_load", 32'(yv8), 32'h1);
    chk("w8_cnt_first", 32'(cnt8), 32'h1);
    en8 = 1'b0;
    tick();
    chk("w8_yq_held", 32'(yq8), 32'h5A);
    chk("w8_yv_drop", 32'(yv8), 32'h0);
    chk("w8_cnt_noch", 32'(cnt8), 32'h1);

    // Restart counter, then 5 toggles and 3 hold cycles
    rst8 = 1'b1; a8 = 8'h00;
    tick();
    chk("w8_cnt_clr", 32'(cnt8), 32'h0);
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = tv[i];
      tick();
      chk("w8_cnt_tog", 32'(cnt8), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w8_cnt_stay", 32'(cnt8), 32'd5);
    end

    // CNT_W=3 saturation over 10 toggles
    rst3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a3 = ~a3;
      tick();
      chk("c3_cnt_sat", 32'(cnt3), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    // Mid-stream reset with toggle_cnt=4
    rst8 = 1'b1; a8 = 8'h00;
    tick();
    rst8 = 1'b0; en8 = 1'b1;
    a8 = 8'h0F; tick();
    a8 = 8'h00; tick();
    a8 = 8'h0F; tick();
    a8 = 8'h00; tick();
    chk("w8_cnt_pre", 32'(cnt8), 32'd4);
    a8 = 8'h0F; rst8 = 1'b1;
    tick();
    chk("w8_yq_midrst", 32'(yq8), 32'hFF);
    chk("w8_yv_midrst", 32'(yv8), 32'h0);
    chk("w8_cnt_midrst", 32'(cnt8), 32'h0);
    rst8 = 1'b0;
    tick();
    chk("w8_yq_post", 32'(yq8), 32'hF0);
    chk("w8_yv_post", 32'(yv8), 32'h1);
    chk("w8_cnt_post", 32'(cnt8), 32'h1);

`ifdef NOT_GATE_SELFCHECK_EN
    for (int i = 0; i < 20; i++) begin
      a8  = 8'($urandom);
      en8 = 1'($urandom_range(0, 1));
      tick();
      chk("sc_clean", 32'(ce8), 32'h0);
    end
    en8 = 1'b1; a8 = 8'h00;
    tick();
    force u8.y_q_q = 8'h00;
    tick();
    release u8.y_q_q;
    chk("sc_err_set", 32'(ce8), 32'h1);
    tick();
    chk("sc_err_sticky", 32'(ce8), 32'h1);
    rst8 = 1'b1;
    tick();
    chk("sc_err_clr", 32'(ce8), 32'h0);
    rst8 = 1'b0;
`else
    chk("ce8_tied", 32'(ce8), 32'h0);
    chk("ce3_tied", 32'(ce3), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
